msg_arb_sender: RTL and testbench

MSG_ARB_SENDER -- requirements
Module: msg_arb_sender

---
 rtl/msg_arb_sender.sv | 192 +++++++++++++++++++
 tb/tb_msg_arb_sender.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_arb_sender.sv
// msg_arb_sender: per-channel message snapshot + round-robin arbiter + byte serialiser.
// Each channel captures its message on a single-cycle trigger. One pending channel at a
// time is granted round-robin and its message is pushed MSB byte first into a downstream
// FIFO, honouring the FIFO full flag.
// Optional feature: define MSG_CRLF_EN to append 8'h0D 8'h0A after every message.
module msg_arb_sender #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned MSG_BYTES = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             ch_trig,
   input  logic [NUM_CH*MSG_BYTES*8-1:0] ch_data,
   input  logic                          full,
   output logic                          push,
   output logic [7:0]                    o_data,
   output logic                          busy,
   output logic [NUM_CH-1:0]             overrun,
   input  logic                          ovr_clr
);

   localparam int unsigned MSG_BITS = MSG_BYTES * 8;
   localparam int unsigned CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned BW       = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;

`ifdef MSG_CRLF_EN
   typedef enum logic [2:0] {StIdle, StLoad, StSend, StCr, StLf} state_t;
`else
   typedef enum logic [1:0] {StIdle, StLoad, StSend} state_t;
`endif

   state_t                r_state;
   state_t                w_state_next;

   logic [MSG_BITS-1:0]   r_snap [NUM_CH];
   logic [NUM_CH-1:0]     r_pending;
   logic [NUM_CH-1:0]     w_pending_next;
   logic [NUM_CH-1:0]     r_overrun;
   logic [NUM_CH-1:0]     w_overrun_next;

   logic [CW-1:0]         r_grant;
   logic [CW-1:0]         r_last_grant;
   logic [CW-1:0]         w_rr_grant;
   logic                  w_rr_valid;

   logic [MSG_BITS-1:0]   r_shift;
   logic [BW-1:0]         r_cnt;

   logic                  w_take_grant;
   logic                  w_load;
   logic                  w_shift_en;

   assign overrun = r_overrun;

   // Round-robin search starting at last_grant+1; the nearest pending channel wins.
   always_comb begin
      logic [CW-1:0] idx;
      idx        = '0;
      w_rr_valid = 1'b0;
      w_rr_grant = r_last_grant;
      // Walk from the farthest candidate to the nearest so the nearest overwrites.
      for (int i = NUM_CH; i > 0; i--) begin
         idx = CW'((32'(r_last_grant) + 32'(i)) % NUM_CH);
         if (r_pending[idx]) begin
            w_rr_valid = 1'b1;
            w_rr_grant = idx;
         end
      end
   end

   // FSM next state and the combinational FIFO-side outputs.
   always_comb begin
      w_state_next = r_state;
      push         = 1'b0;
      busy         = 1'b0;
      o_data       = r_shift[MSG_BITS-1 -: 8];
      w_take_grant = 1'b0;
      w_load       = 1'b0;
      w_shift_en   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_rr_valid) begin
               w_take_grant = 1'b1;
               w_state_next = StLoad;
            end
         end
         StLoad: begin
            busy         = 1'b1;
            w_load       = 1'b1;
            w_state_next = StSend;
         end
         StSend: begin
            busy = 1'b1;
            if (!full) begin
               push       = 1'b1;
               w_shift_en = 1'b1;
               if (r_cnt == '0) begin
`ifdef MSG_CRLF_EN
                  w_state_next = StCr;
`else
                  w_state_next = StIdle;
`endif
               end
            end
         end
`ifdef MSG_CRLF_EN
         StCr: begin
            busy   = 1'b1;
            o_data = 8'h0D;
            if (!full) begin
               push         = 1'b1;
               w_state_next = StLf;
            end
         end
         StLf: begin
            busy   = 1'b1;
            o_data = 8'h0A;
            if (!full) begin
               push         = 1'b1;
               w_state_next = StIdle;
            end
         end
`endif
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // Pending and overrun next state; a trigger beats both the LOAD clear and ovr_clr.
   always_comb begin
      w_pending_next = r_pending;
      w_overrun_next = ovr_clr ? '0 : r_overrun;
      if (w_load) begin
         w_pending_next[r_grant] = 1'b0;
      end
      w_pending_next = w_pending_next | ch_trig;
      w_overrun_next = w_overrun_next | (ch_trig & r_pending);
   end

   // FSM state, pending and overrun registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= StIdle;
         r_pending <= '0;
         r_overrun <= '0;
      end else begin
         r_state   <= w_state_next;
         r_pending <= w_pending_next;
         r_overrun <= w_overrun_next;
      end
   end

   // Per-channel snapshots; latest trigger wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NUM_CH; k++) begin
            r_snap[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (ch_trig[k]) begin
               r_snap[k] <= ch_data[k*MSG_BITS +: MSG_BITS];
            end
         end
      end
   end

   // Grant bookkeeping, shift register and byte counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_grant      <= '0;
         r_last_grant <= CW'(NUM_CH - 1);
         r_shift      <= '0;
         r_cnt        <= '0;
      end else begin
         if (w_take_grant) begin
            r_grant      <= w_rr_grant;
            r_last_grant <= w_rr_grant;
         end
         if (w_load) begin
            // Reads the registered snapshot, so a same-cycle trigger is sent next time.
            r_shift <= r_snap[r_grant];
            r_cnt   <= BW'(MSG_BYTES - 1);
         end else if (w_shift_en) begin
            r_shift <= r_shift << 8;
            r_cnt   <= r_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_msg_arb_sender.sv
// Directed bench for msg_arb_sender (NUM_CH=4, MSG_BYTES=8) with a byte scoreboard.
// Honours MSG_CRLF_EN by expecting the trailing 0D 0A per message.
module tb_msg_arb_sender;

   localparam int NC = 4;
   localparam int MB = 8;
`ifdef MSG_CRLF_EN
   localparam int EXTRA = 2;
`else
   localparam int EXTRA = 0;
`endif

   logic               clk;
   logic               rst;
   logic [NC-1:0]      ch_trig;
   logic [NC*MB*8-1:0] ch_data;
   logic               full;
   logic               push;
   logic [7:0]         o_data;
   logic               busy;
   logic [NC-1:0]      overrun;
   logic               ovr_clr;

   msg_arb_sender #(
      .NUM_CH    (NC),
      .MSG_BYTES (MB)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .ch_trig (ch_trig),
      .ch_data (ch_data),
      .full    (full),
      .push    (push),
      .o_data  (o_data),
      .busy    (busy),
      .overrun (overrun),
      .ovr_clr (ovr_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   int         n_push = 0;
   int         n_busy = 0;
   logic [7:0] q[$];
   logic       s_push;
   logic       s_busy;
   logic [7:0] s_data;
   logic [3:0] s_ovr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Negedge sample: scoreboard pop on every push, plus snapshot for directed checks.
   task automatic mon();
      s_push = push;
      s_busy = busy;
      s_data = o_data;
      s_ovr  = overrun;
      if (busy === 1'b1) n_busy++;
      if (push !== 1'b0) begin
         n_push++;
         if (q.size() == 0) check("unexpected_push", 32'(push), 32'd0);
         else check("byte", 32'(o_data), 32'(q.pop_front()));
      end
   endtask

   // Sample the current cycle, then move to just after the next rising edge.
   task automatic cyc();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_msg(input logic [63:0] d);
      for (int i = MB - 1; i >= 0; i--) q.push_back(d[i*8 +: 8]);
`ifdef MSG_CRLF_EN
      q.push_back(8'h0D);
      q.push_back(8'h0A);
`endif
   endtask

   task automatic wait_drain(input int bound);
      for (int i = 0; i < bound; i++) begin
         if (q.size() == 0 && s_busy === 1'b0) break;
         cyc();
      end
      check("drain", 32'(q.size() == 0 && s_busy === 1'b0), 32'd1);
   endtask

   task automatic wait_pushes(input int n, input int bound);
      int seen;
      seen = 0;
      for (int i = 0; i < bound && seen < n; i++) begin
         cyc();
         if (s_push === 1'b1) seen++;
      end
      check("push_wait", 32'(seen), 32'(n));
   endtask

   initial begin
      int np0;
      int nb0;
      int lat;
      logic [63:0] d0;
      logic [63:0] d1;
      logic [63:0] d2;
      logic [63:0] d3;

      rst = 1'b0; ch_trig = '0; ch_data = '0; full = 1'b0; ovr_clr = 1'b0;
      s_push = 1'b0; s_busy = 1'b0; s_data = '0; s_ovr = '0;
      #2;
      repeat (3) cyc();
      check("rst_push", 32'(s_push), 32'd0);
      check("rst_data", 32'(s_data), 32'h00);
      check("rst_busy", 32'(s_busy), 32'd0);
      check("rst_ovr", 32'(s_ovr), 32'd0);
      rst = 1'b1;
      repeat (2) cyc();

      // All four channels at once: served ch0..ch3, no interleaving.
      d0 = "CH0msgAA"; d1 = "ch1MSGbb"; d2 = "Ch2-data"; d3 = "cH3_last";
      ch_data = {d3, d2, d1, d0};
      expect_msg(d0); expect_msg(d1); expect_msg(d2); expect_msg(d3);
      np0 = n_push;
      ch_trig = 4'b1111;
      cyc();
      ch_trig = '0;
      wait_drain(200);
      check("rr_count", 32'(n_push - np0), 32'(4 * (MB + EXTRA)));

      // Single message: latency, busy length and byte count.
      d0 = "12:34:56";
      ch_data[0 +: 64] = d0;
      expect_msg(d0);
      np0 = n_push; nb0 = n_busy;
      ch_trig = 4'b0001;
      cyc();
      ch_trig = '0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (s_push === 1'b1) break;
         lat++;
      end
      check("first_push_latency", 32'(lat), 32'd2);
      wait_drain(60);
      check("busy_cycles", 32'(n_busy - nb0), 32'(MB + 1 + EXTRA));
      check("msg_count", 32'(n_push - np0), 32'(MB + EXTRA));

      // Stall for 5 cycles after the third byte.
      d2 = "ABCDEFGH";
      ch_data[2*64 +: 64] = d2;
      expect_msg(d2);
      np0 = n_push;
      ch_trig = 4'b0100;
      cyc();
      ch_trig = '0;
      wait_pushes(3, 30);
      full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("stall_push", 32'(s_push), 32'd0);
         check("stall_data", 32'(s_data), 32'h44);
      end
      full = 1'b0;
      wait_drain(60);
      check("stall_count", 32'(n_push - np0), 32'(MB + EXTRA));

      // Double trigger on ch2 while ch1 sends: only the second data goes out.
      d1 = "ch1 busy";
      ch_data[64 +: 64] = d1;
      expect_msg(d1);
      ch_trig = 4'b0010;
      cyc();
      ch_trig = '0;
      wait_pushes(1, 20);
      ch_data[2*64 +: 64] = "lostdata";
      ch_trig = 4'b0100;
      cyc();
      ch_trig = '0;
      cyc();
      d2 = "keptdata";
      ch_data[2*64 +: 64] = d2;
      expect_msg(d2);
      ch_trig = 4'b0100;
      cyc();
      ch_trig = '0;
      cyc();
      check("ovr_set", 32'(s_ovr), 32'h4);
      wait_drain(100);
      check("ovr_sticky", 32'(s_ovr), 32'h4);
      ovr_clr = 1'b1;
      cyc();
      ovr_clr = 1'b0;
      cyc();
      check("ovr_clr", 32'(s_ovr), 32'h0);

      // Set beats a simultaneous clear.
      ch_data[3*64 +: 64] = "first!!!";
      ch_trig = 4'b1000;
      cyc();
      d3 = "second!!";
      ch_data[3*64 +: 64] = d3;
      expect_msg(d3);
      ovr_clr = 1'b1;
      cyc();
      ch_trig = '0;
      ovr_clr = 1'b0;
      cyc();
      check("ovr_set_beats_clr", 32'(s_ovr), 32'h8);
      wait_drain(60);
      ovr_clr = 1'b1;
      cyc();
      ovr_clr = 1'b0;

      // Trigger on ch1 during its own LOAD cycle: old data, then new data.
      d0 = "old_snap";
      d1 = "new_snap";
      ch_data[64 +: 64] = d0;
      expect_msg(d0);
      expect_msg(d1);
      np0 = n_push;
      ch_trig = 4'b0010;
      cyc();
      ch_trig = '0;
      cyc();
      ch_data[64 +: 64] = d1;
      ch_trig = 4'b0010;
      cyc();
      ch_trig = '0;
      check("load_cycle", 32'({s_busy, s_push}), 32'b10);
      wait_drain(100);
      check("load_race_count", 32'(n_push - np0), 32'(2 * (MB + EXTRA)));

      // Reset during byte 5: immediate silence, no resume.
      d0 = "RSTmsg!!";
      ch_data[0 +: 64] = d0;
      expect_msg(d0);
      ch_trig = 4'b0001;
      cyc();
      ch_trig = '0;
      wait_pushes(4, 30);
      #1;
      rst = 1'b0;
      #1;
      check("rst_mid_push", 32'(push), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_data", 32'(o_data), 32'h00);
      q.delete();
      cyc();
      check("rst_mid_ovr", 32'(s_ovr), 32'h0);
      rst = 1'b1;
      np0 = n_push;
      repeat (20) cyc();
      check("no_resume", 32'(n_push - np0), 32'd0);
      check("queue_empty", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
